// File: rtl/dll_pkg.sv
// Shared DLL constants, FSM state encoding and a small elaboration helper.
// Latency: n/a (declarations only).
// Backpressure: n/a; used by the lock controller, the delay-line wrapper and the register block.
package dll_pkg;

  localparam int         DLL_SEL_W   = 9;
  localparam logic [8:0] DLL_TAP_MAX = 9'd511;
  localparam logic [8:0] DLL_TAP_MID = 9'h100;

  typedef enum logic [1:0] {
    DLL_IDLE  = 2'd0,
    DLL_SAR   = 2'd1,
    DLL_TRACK = 2'd2
  } dll_state_e;

  // Larger of two elaboration-time values; sizes the shared settle/track counter.
  function automatic int dll_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dll_lock_ctrl_if.sv
// Control/status bundle between the register block, the phase detector and the DLL lock controller.
// Latency: n/a (wires only).
// Backpressure: none; levels and single-cycle pulses, no handshake.
// Ports: i_en, i_start, i_pd_late, i_manual, i_manual_sel -> controller;
//        o_sel_index, o_locked, o_busy, o_sat_err <- controller.
interface dll_lock_ctrl_if;
  import dll_pkg::*;

  logic                 i_en;
  logic                 i_start;
  logic                 i_pd_late;
  logic                 i_manual;
  logic [DLL_SEL_W-1:0] i_manual_sel;
  logic [DLL_SEL_W-1:0] o_sel_index;
  logic                 o_locked;
  logic                 o_busy;
  logic                 o_sat_err;

  // Register block / detector side.
  modport master (
    output i_en, i_start, i_pd_late, i_manual, i_manual_sel,
    input  o_sel_index, o_locked, o_busy, o_sat_err
  );

  // Lock controller side.
  modport slave (
    input  i_en, i_start, i_pd_late, i_manual, i_manual_sel,
    output o_sel_index, o_locked, o_busy, o_sat_err
  );

endinterface

// File: rtl/dll_sync2.sv
// Two-flop synchroniser for the asynchronous phase-detector output.
// Latency: 2 clk edges from d to q.
// Backpressure: none.
// Ports: clk, rst_n (async active-low, clears both flops), d (async in), q (synchronised out).
module dll_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dll_lock_ctrl.sv
// Tap-select controller for the 512-tap DLL: SAR lock search, then periodic +/-1 tracking, with manual override.
// Latency: lock 9*SETTLE_CYCLES edges after i_start; tracking steps every TRACK_INTERVAL edges; manual follows in 1 cycle.
// Backpressure: none; i_start restarts in any state, i_manual and !i_en preempt everything else.
// Ports: clk, rst_n (async active-low); bus (slave modport): enable/start/manual controls and the
//        raw detector input in; registered tap select, locked, busy and sticky saturation flag out.
module dll_lock_ctrl
  import dll_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 8,
  parameter int TRACK_INTERVAL = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  dll_lock_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(dll_max(SETTLE_CYCLES, TRACK_INTERVAL));

  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRACK_RELOAD  = CNT_W'(TRACK_INTERVAL - 1);

  localparam logic [1:0] S_IDLE  = DLL_IDLE;
  localparam logic [1:0] S_SAR   = DLL_SAR;
  localparam logic [1:0] S_TRACK = DLL_TRACK;

  logic [1:0]           state;
  logic [3:0]           bit_ptr;
  logic [CNT_W-1:0]     cnt;
  logic [DLL_SEL_W-1:0] sel;
  logic                 locked;
  logic                 busy;
  logic                 sat_err;
  logic                 pd_s;

  logic [DLL_SEL_W-1:0] bit_mask;
  logic [DLL_SEL_W-1:0] next_mask;
  logic [DLL_SEL_W-1:0] sar_next;

  dll_sync2 u_pd_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.i_pd_late),
    .q     (pd_s)
  );

  // SAR trial update: drop the bit under test if the line is late, then
  // arm the next lower bit as the new trial. At bit 0 next_mask is zero.
  always_comb begin
    bit_mask  = DLL_SEL_W'(1) << bit_ptr;
    next_mask = bit_mask >> 1;
    sar_next  = (pd_s ? (sel & ~bit_mask) : sel) | next_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_ptr <= 4'd0;
      cnt     <= '0;
      sel     <= '0;
      locked  <= 1'b0;
      busy    <= 1'b0;
      sat_err <= 1'b0;
    end else if (bus.i_manual) begin
      state   <= S_IDLE;
      sel     <= bus.i_manual_sel;
      locked  <= 1'b0;
      busy    <= 1'b0;
    end else if (!bus.i_en) begin
      state   <= S_IDLE;
      locked  <= 1'b0;
      busy    <= 1'b0;
    end else if (bus.i_start) begin
      state   <= S_SAR;
      sel     <= DLL_TAP_MID;
      bit_ptr <= 4'd8;
      cnt     <= SETTLE_RELOAD;
      busy    <= 1'b1;
      locked  <= 1'b0;
      sat_err <= 1'b0;
    end else begin
      case (state)
        S_SAR: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            sel <= sar_next;
            if (bit_ptr != 4'd0) begin
              bit_ptr <= bit_ptr - 4'd1;
              cnt     <= SETTLE_RELOAD;
            end else begin
              state  <= S_TRACK;
              busy   <= 1'b0;
              locked <= 1'b1;
              cnt    <= TRACK_RELOAD;
            end
          end
        end
        S_TRACK: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cnt <= TRACK_RELOAD;
            // Late clock means too much delay: step down; otherwise step up.
            // Hitting either end of the line clamps the tap and drops lock
            // until software restarts the search.
            if (pd_s) begin
              if (sel == '0) begin
                sat_err <= 1'b1;
                locked  <= 1'b0;
              end else begin
                sel <= sel - DLL_SEL_W'(1);
              end
            end else begin
              if (sel == DLL_TAP_MAX) begin
                sat_err <= 1'b1;
                locked  <= 1'b0;
              end else begin
                sel <= sel + DLL_SEL_W'(1);
              end
            end
          end
        end
        S_IDLE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_sel_index = sel;
  assign bus.o_locked    = locked;
  assign bus.o_busy      = busy;
  assign bus.o_sat_err   = sat_err;

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Bench for dll_lock_ctrl: a monotonic detector model drives the phase input,
// every output change is predicted as an (edge, value) event and checked in order.
// Directed scenarios first, then randomized ones.
module tb_dll_lock_ctrl;
  import dll_pkg::*;

  localparam int S  = 8;
  localparam int TI = 32;

  localparam int A_EN      = 0;
  localparam int A_MAN     = 1;
  localparam int A_RST     = 2;
  localparam int A_RESTART = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dll_lock_ctrl_if bus ();

  dll_lock_ctrl #(
    .SETTLE_CYCLES  (S),
    .TRACK_INTERVAL (TI)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Detector model: late exactly when the current tap exceeds the threshold.
  int thr_v = 0;
  assign bus.i_pd_late = (int'(bus.o_sel_index) > thr_v);

  int edges    = 0;
  int checks   = 0;
  int failures = 0;
  int next_k   = 0;

  typedef struct {
    int         cyc;
    logic [11:0] v;
  } ev_t;

  ev_t         sb[$];
  logic [11:0] exp_last = '0;

  initial forever begin
    @(posedge clk);
    edges++;
  end

  function automatic logic [11:0] pk(input logic sat, input logic busy, input logic lk,
                                     input logic [8:0] sel);
    return {sat, busy, lk, sel};
  endfunction

  // Record an expected output change; repeats of the current value are not events.
  task automatic push_ev(input int c, input logic [11:0] v);
    if (v !== exp_last) begin
      sb.push_back('{cyc: c, v: v});
      exp_last = v;
    end
  endtask

  // Expected events of a search started at edge k against threshold thr,
  // truncated before edge x (where something else takes over).
  // After deciding bit b the tap agrees with thr on bits >= b and holds a
  // trial 1 at bit b-1; after the last decision it equals thr.
  task automatic plan_lock(input int k, input int thr, input int x);
    int          c;
    logic [8:0]  tap;
    logic        lk;
    logic        sat;
    if (k >= x) return;
    push_ev(k, pk(1'b0, 1'b1, 1'b0, DLL_TAP_MID));
    for (int b = 8; b >= 1; b--) begin
      c = k + S * (9 - b);
      if (c >= x) return;
      tap = 9'((thr & ~((1 << b) - 1)) | (1 << (b - 1)));
      push_ev(c, pk(1'b0, 1'b1, 1'b0, tap));
    end
    c = k + 9 * S;
    if (c >= x) return;
    tap = 9'(thr);
    lk  = 1'b1;
    sat = 1'b0;
    push_ev(c, pk(sat, 1'b0, lk, tap));
    for (c = k + 9 * S + TI; c < x; c += TI) begin
      if (int'(tap) > thr) begin
        if (tap == 9'd0) begin sat = 1'b1; lk = 1'b0; end
        else tap = tap - 9'd1;
      end else begin
        if (tap == 9'd511) begin sat = 1'b1; lk = 1'b0; end
        else tap = tap + 9'd1;
      end
      push_ev(c, pk(sat, 1'b0, lk, tap));
    end
  endtask

  task automatic at_neg(input int e);
    while (edges < e) @(negedge clk);
  endtask

  task automatic check_now(input string nm, input logic [11:0] got, input logic [11:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", nm, got, req);
    end
  endtask

  task automatic do_start(input int k, input int thr);
    at_neg(k - 1);
    thr_v          = thr;
    bus.i_en       = 1'b1;
    bus.i_start    = 1'b1;
    at_neg(k);
    bus.i_start    = 1'b0;
  endtask

  task automatic gap();
    int n;
    n = int'($urandom_range(2, 2 * TI));
    at_neg(edges + n);
    next_k = edges + 2;
  endtask

  // One search started at next_k, interrupted at k+xoff by action act.
  task automatic run_scn(input int thr, input int xoff, input int act, input int mval);
    int k;
    int x;
    int n;
    int m;
    k = next_k;
    x = k + xoff;
    plan_lock(k, thr, x);
    do_start(k, thr);
    case (act)
      A_RESTART: next_k = x;
      A_EN: begin
        at_neg(x - 1);
        push_ev(x, pk(exp_last[11], 1'b0, 1'b0, exp_last[8:0]));
        bus.i_en = 1'b0;
        gap();
      end
      A_MAN: begin
        at_neg(x - 1);
        push_ev(x, pk(exp_last[11], 1'b0, 1'b0, 9'(mval)));
        bus.i_manual     = 1'b1;
        bus.i_manual_sel = 9'(mval);
        n = int'($urandom_range(1, 4));
        for (int j = 1; j <= n; j++) begin
          at_neg(x - 1 + j);
          m = int'($urandom_range(0, 511));
          push_ev(x + j, pk(exp_last[11], 1'b0, 1'b0, 9'(m)));
          bus.i_manual_sel = 9'(m);
        end
        at_neg(x + n);
        bus.i_manual = 1'b0;
        gap();
      end
      default: begin
        at_neg(x - 1);
        push_ev(x, '0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gap();
      end
    endcase
  endtask

  // Monitor: every observed output change must match the oldest expected event.
  initial begin : monitor
    logic [11:0] seen;
    logic [11:0] cur;
    ev_t         e;
    seen = '0;
    forever begin
      @(negedge clk);
      cur = {bus.o_sat_err, bus.o_busy, bus.o_locked, bus.o_sel_index};
      if (cur !== seen) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change edge=%0d got=%h required=no change", edges, cur);
        end else begin
          e = sb.pop_front();
          if (e.cyc != edges) begin
            failures++;
            $display("FAIL event_edge got=%0d required=%0d value=%h", edges, e.cyc, e.v);
          end
          checks++;
          if (cur !== e.v) begin
            failures++;
            $display("FAIL event_value edge=%0d got=%h required=%h", edges, cur, e.v);
          end
        end
        seen = cur;
      end
    end
  end

  int d_thr [7] = '{300, 0, 511, 123, 400, 200, 77};
  int d_xoff[7] = '{9*S + 3*TI + 5, 9*S + 2*TI + 1, 9*S + 2*TI + 3, 4*S + 3,
                    9*S + TI + 2, 3*S + 2, 5*S + 2};
  int d_act [7] = '{A_EN, A_EN, A_RESTART, A_RESTART, A_EN, A_MAN, A_RST};

  initial begin : stim
    int thr;
    int act;
    int r;
    bus.i_en         = 1'b0;
    bus.i_start      = 1'b0;
    bus.i_manual     = 1'b0;
    bus.i_manual_sel = '0;

    // Inputs toggle freely under reset; outputs must not move.
    repeat (20) begin
      @(negedge clk);
      bus.i_en         = 1'($urandom_range(0, 1));
      bus.i_start      = 1'($urandom_range(0, 1));
      bus.i_manual     = 1'($urandom_range(0, 1));
      bus.i_manual_sel = 9'($urandom_range(0, 511));
      thr_v            = int'($urandom_range(0, 511));
    end
    check_now("reset_outputs", {bus.o_sat_err, bus.o_busy, bus.o_locked, bus.o_sel_index}, '0);
    bus.i_en     = 1'b0;
    bus.i_start  = 1'b0;
    bus.i_manual = 1'b0;
    rst_n        = 1'b1;
    repeat (100) @(negedge clk);
    check_now("idle_outputs", {bus.o_sat_err, bus.o_busy, bus.o_locked, bus.o_sel_index}, '0);
    next_k = edges + 2;

    for (int i = 0; i < 7; i++) run_scn(d_thr[i], d_xoff[i], d_act[i], 'h1A5);

    for (int i = 0; i < 25; i++) begin
      r = int'($urandom_range(0, 9));
      thr = (r == 0) ? 0 : (r == 1) ? 511 : int'($urandom_range(0, 511));
      act = int'($urandom_range(0, 3));
      if (i == 24 && act == A_RESTART) act = A_EN;
      run_scn(thr, int'($urandom_range(1, 9*S + 3*TI)), act, int'($urandom_range(0, 511)));
    end

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending_events got=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dll_lock_ctrl.md
# dll_lock_ctrl

Closed-loop tap-select controller for the 512-tap eMMC DLL delay line. It drives the delay line's 9-bit tap select from a successive-approximation (SAR) search over a synchronised phase-detector input. After lock it keeps the tap aligned by periodic ±1 tracking steps, and it supports a register-driven manual override. It sits directly upstream of the delay line, between the AHB configuration registers and the line's tap-select input.

## Interface
Parameters:
- SETTLE_CYCLES, 8, cycles per SAR step or tracking evaluation (line settle time plus synchroniser latency); legal range 4..255.
- TRACK_INTERVAL, 64, cycles between tracking evaluations once locked; legal range 4..65535.

Ports:
- clk  in  1  single DLL controller clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  controller enable; low forces IDLE.
- i_start  in  1  single-cycle pulse that starts or restarts the lock search.
- i_pd_late  in  1  asynchronous phase-detector output; 1 means the delayed clock lags, so there is too much delay.
- i_manual  in  1  manual override enable.
- i_manual_sel  in  9  tap value to use in manual mode.
- o_sel_index  out  9  tap select to the delay line (registered).
- o_locked  out  1  SAR completed and tracking is in range.
- o_busy  out  1  SAR search in progress.
- o_sat_err  out  1  sticky flag: tracking hit tap 0 or tap 511.

## Operation
- i_pd_late passes through a 2-flop synchroniser. All decisions use the synchronised value pd_s.
- FSM states are IDLE, SAR, TRACK. Internal state is bit_ptr[3:0] and down-counter cnt.
- Priority order, highest first: i_manual, then !i_en, then i_start, then the normal FSM.
- In manual mode: o_sel_index <= i_manual_sel every cycle, state = IDLE, o_locked = 0, o_busy = 0.
- When i_en = 0: state goes to IDLE, o_sel_index holds its value, o_locked = 0, o_busy = 0.
- i_start with i_en = 1, accepted in any state:
  - o_sel_index <= 9'h100, bit_ptr <= 8, cnt <= SETTLE_CYCLES-1.
  - State goes to SAR; o_busy = 1, o_locked = 0, o_sat_err <= 0.
- SAR state:
  - While cnt != 0, decrement cnt.
  - When cnt == 0: if pd_s, clear bit[bit_ptr].
  - If bit_ptr != 0, also set bit[bit_ptr-1], decrement bit_ptr and reload cnt.
  - Otherwise go to TRACK: o_busy <= 0, o_locked <= 1, cnt <= TRACK_INTERVAL-1.
- TRACK state:
  - When cnt == 0: if pd_s, o_sel_index decrements; otherwise it increments. Then reload cnt.
  - The tap saturates at 0 and 511.
  - A decrement at 0 or an increment at 511 sets o_sat_err and clears o_locked. The state stays TRACK and the tap stays clamped.
  - o_locked never re-asserts without a new i_start.
- Result: with a monotonic detector that is late exactly for taps > T, SAR ends with o_sel_index = T.

## Timing
- Reset values: o_sel_index = 0, o_locked = 0, o_busy = 0, o_sat_err = 0, state = IDLE, synchroniser flops = 0.
- Edge numbering: the start is captured at edge k.
  - o_sel_index = 0x100 from edge k.
  - Each SAR bit decision takes SETTLE_CYCLES edges.
  - o_locked rises and o_busy falls at edge k + 9·SETTLE_CYCLES.
- The first tracking step occurs TRACK_INTERVAL edges after lock, then once every TRACK_INTERVAL edges.
- Every o_sel_index change is at most one edge per SETTLE_CYCLES (SAR) or per TRACK_INTERVAL (tracking). Manual mode is the exception and follows i_manual_sel with 1-cycle latency.
- Releasing i_manual returns the controller to IDLE with o_sel_index holding its last manual value. Leaving IDLE requires i_start.
- Reset asserted mid-search aborts immediately to the reset values. No partial result is retained.

## Structure
- Shared package dll_pkg holds:
  - DLL_SEL_W = 9, DLL_TAP_MAX = 511, DLL_TAP_MID = 9'h100;
  - the state enum (IDLE, SAR, TRACK);
  - shared with the delay-line wrapper and register block.
- One sub-module, dll_sync2: a 2-flop synchroniser for i_pd_late, reset to 0 by rst_n.
- The counter width is derived from max(SETTLE_CYCLES, TRACK_INTERVAL) via $clog2.

## Test plan
- Reset: hold rst_n low and toggle all inputs -> all outputs stay 0. Release, idle 100 cycles -> outputs unchanged.
- SAR lock: detector model late when tap > 300, SETTLE_CYCLES = 8, pulse i_start -> o_busy for 72 cycles, o_locked at edge k+72, o_sel_index = 300. Repeat with T = 0 and T = 511 -> final taps 0 and 511.
- Tracking and saturation: lock at 511, then force the model early -> after TRACK_INTERVAL the tap stays 511, o_sat_err = 1, o_locked = 0. A new i_start clears o_sat_err.
- Restart: pulse i_start at SAR bit 4, then again -> search restarts from 0x100 and the lock time is measured from the second pulse.
- Manual override: i_manual = 1, i_manual_sel = 0x1A5 mid-SAR -> o_sel_index = 0x1A5 next cycle, o_busy = 0, o_locked = 0. Release -> IDLE, tap held at 0x1A5.
- Reset and enable: assert rst_n at SAR bit 3 -> next cycle outputs are at reset values. Drop i_en while locked -> o_locked = 0, tap held, no further steps.
